// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between an initiator and a slave register block.
interface axi4_lite_master_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns one local command into one AXI4-Lite read or write,
// with a single transaction outstanding and every output driven from a flop.
module axi4_lite_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  axi4_lite_master_if.master        m_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

  state_e                    state_q,     state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      awvalid_q,   awvalid_d;
  logic                      wvalid_q,    wvalid_d;
  logic                      bready_q,    bready_d;
  logic                      arvalid_q,   arvalid_d;
  logic                      rready_q,    rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q,  rsp_resp_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q,      addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q,     wstrb_d;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_q & m_axi.awready;
  assign w_hs  = wvalid_q & m_axi.wready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      // AW and W retire independently; a channel already done counts as complete.
      WR_ADDR_DATA: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi.bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axi.bresp;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end
      end

      RD_ADDR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axi.rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = m_axi.rresp;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a reactive slave with scripted wait states, and a
// timeline model that predicts, per transaction, the cycle window of every output.
module tb_axi4_lite_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic           ACLK;
  logic           ARESET;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_write;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic [SW-1:0]  cmd_wstrb;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_rdata;
  logic [1:0]     rsp_resp;

  axi4_lite_master_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_master #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .m_axi     (bus)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Slave behaviour knobs: wait cycles before each ready/valid.
  int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0, rsp_dly = 0;
  bit         ready_first = 1'b0;
  logic [1:0] s_bresp = 2'b00;
  logic [1:0] s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;

  // Edge k is the k-th rising edge; "cycle k" is the interval after edge k.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int a, aw_hs, w_hs, b_start, b_hs, ar_hs, rd_hs, d, r, rst;
  } txn_t;

  txn_t txq[$];
  int   last_r = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s timeout cyc=%0d got=none want=event", name, cyc);
  endtask

  function automatic bit win(input int c, input int lo, input int hi, input int rst);
    return (c >= lo) && (c < hi) && (c < rst);
  endfunction

  // Reactive slave: samples handshakes mid-cycle, updates just after the edge.
  bit f_aw, f_w, f_b, f_ar, f_r, v_aw, v_w, v_ar, v_rsp, f_rsp, rst_s;
  bit aw_done, w_done, b_arm, r_arm;
  int aw_cnt, w_cnt, ar_cnt, rsp_cnt, b_cnt, r_cnt;

  initial begin : slave
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid  = 1'b0; bus.rvalid = 1'b0; bus.bresp = 2'b00;
    bus.rresp   = 2'b00; bus.rdata = '0; rsp_ready = 1'b0;
    aw_done = 0; w_done = 0; b_arm = 0; r_arm = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0; b_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge ACLK);
      f_aw  = bus.awvalid && bus.awready;
      f_w   = bus.wvalid && bus.wready;
      f_b   = bus.bvalid && bus.bready;
      f_ar  = bus.arvalid && bus.arready;
      f_r   = bus.rvalid && bus.rready;
      f_rsp = rsp_valid && rsp_ready;
      v_aw  = bus.awvalid; v_w = bus.wvalid; v_ar = bus.arvalid; v_rsp = rsp_valid;
      rst_s = ARESET;
      @(posedge ACLK);
      #1;
      if (rst_s) begin
        aw_done = 0; w_done = 0; b_arm = 0; r_arm = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0;
        bus.bvalid = 1'b0; bus.rvalid = 1'b0;
      end else begin
        aw_cnt  = (f_aw || !v_aw) ? 0 : aw_cnt + 1;
        w_cnt   = (f_w || !v_w) ? 0 : w_cnt + 1;
        ar_cnt  = (f_ar || !v_ar) ? 0 : ar_cnt + 1;
        rsp_cnt = (f_rsp || !v_rsp) ? 0 : rsp_cnt + 1;
        if (f_aw) aw_done = 1;
        if (f_w)  w_done  = 1;
        if (f_b)  bus.bvalid = 1'b0;
        if (aw_done && w_done) begin
          aw_done = 0; w_done = 0; b_arm = 1; b_cnt = 0;
        end
        if (b_arm) begin
          if (b_cnt == b_dly) begin bus.bvalid = 1'b1; b_arm = 0; end
          else b_cnt++;
        end
        if (f_r) bus.rvalid = 1'b0;
        if (f_ar) begin r_arm = 1; r_cnt = 0; end
        if (r_arm) begin
          if (r_cnt == r_dly) begin bus.rvalid = 1'b1; r_arm = 0; end
          else r_cnt++;
        end
      end
      bus.bresp   = s_bresp;
      bus.rresp   = s_rresp;
      bus.rdata   = s_rdata;
      bus.awready = ready_first || (bus.awvalid && aw_cnt == aw_dly);
      bus.wready  = ready_first || (bus.wvalid && w_cnt == w_dly);
      bus.arready = ready_first || (bus.arvalid && ar_cnt == ar_dly);
      rsp_ready   = rsp_valid && rsp_cnt == rsp_dly;
    end
  end

  logic        e_cmd_ready, e_aw, e_w, e_b, e_ar, e_r, e_rsp;
  logic [31:0] e_awaddr, e_wdata, e_araddr, e_rdata;
  logic [3:0]  e_strb;
  logic [1:0]  e_resp;

  always @(negedge ACLK) begin : compare
    if (check_en) begin
      e_cmd_ready = 1'b1; e_aw = 0; e_w = 0; e_b = 0; e_ar = 0; e_r = 0; e_rsp = 0;
      e_awaddr = 0; e_wdata = 0; e_araddr = 0; e_rdata = 0; e_strb = 0; e_resp = 0;
      foreach (txq[i]) begin
        if (win(cyc, txq[i].a, txq[i].r, txq[i].rst)) e_cmd_ready = 1'b0;
        if (txq[i].wr) begin
          if (win(cyc, txq[i].a, txq[i].aw_hs, txq[i].rst)) begin
            e_aw = 1; e_awaddr = txq[i].addr;
          end
          if (win(cyc, txq[i].a, txq[i].w_hs, txq[i].rst)) begin
            e_w = 1; e_wdata = txq[i].wdata; e_strb = txq[i].strb;
          end
          if (win(cyc, txq[i].b_start, txq[i].b_hs, txq[i].rst)) e_b = 1;
        end else begin
          if (win(cyc, txq[i].a, txq[i].ar_hs, txq[i].rst)) begin
            e_ar = 1; e_araddr = txq[i].addr;
          end
          if (win(cyc, txq[i].ar_hs, txq[i].rd_hs, txq[i].rst)) e_r = 1;
        end
        if (win(cyc, txq[i].d, txq[i].r, txq[i].rst)) begin
          e_rsp = 1; e_rdata = txq[i].rdata; e_resp = txq[i].resp;
        end
      end
      chk("cmd_ready", cmd_ready, e_cmd_ready);
      chk("awvalid", bus.awvalid, e_aw);
      chk("wvalid", bus.wvalid, e_w);
      chk("bready", bus.bready, e_b);
      chk("arvalid", bus.arvalid, e_ar);
      chk("rready", bus.rready, e_r);
      chk("rsp_valid", rsp_valid, e_rsp);
      if (e_aw) chk("awaddr", bus.awaddr, e_awaddr);
      if (e_w) begin
        chk("wdata", bus.wdata, e_wdata);
        chk("wstrb", bus.wstrb, e_strb);
      end
      if (e_ar) chk("araddr", bus.araddr, e_araddr);
      if (e_rsp) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_resp", rsp_resp, e_resp);
      end
    end
  end

  // Predicts the output timeline from the slave knobs, then presents the command.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output int acc);
    txn_t t;
    int   p;
    p = cyc;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb;
    t.a = ((p > last_r) ? p : last_r) + 1;
    t.aw_hs = 0; t.w_hs = 0; t.b_start = 0; t.b_hs = 0; t.ar_hs = 0; t.rd_hs = 0;
    if (wr) begin
      t.aw_hs   = t.a + 1 + aw_dly;
      t.w_hs    = t.a + 1 + w_dly;
      t.b_start = (t.aw_hs > t.w_hs) ? t.aw_hs : t.w_hs;
      t.b_hs    = t.b_start + b_dly + 1;
      t.d       = t.b_hs;
      t.rdata   = 32'h0;
      t.resp    = s_bresp;
    end else begin
      t.ar_hs = t.a + 1 + ar_dly;
      t.rd_hs = t.ar_hs + r_dly + 1;
      t.d     = t.rd_hs;
      t.rdata = s_rdata;
      t.resp  = s_rresp;
    end
    t.r   = t.d + rsp_dly + 1;
    t.rst = 32'h3fff_ffff;
    last_r = t.r;
    txq.push_back(t);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    acc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge ACLK);
      if (cmd_ready) begin acc = cyc; break; end
    end
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
    if (acc < 0) timeout("cmd_accept");
  endtask

  task automatic wait_rsp(input string name, input int exp_lat, input int acc,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_resp, output int d);
    d = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge ACLK);
      if (rsp_valid) begin d = cyc; break; end
    end
    if (d < 0) timeout({name, "_rsp"});
    else begin
      chk({name, "_latency"}, d - acc, exp_lat);
      chk({name, "_rdata"}, rsp_rdata, exp_rdata);
      chk({name, "_resp"}, rsp_resp, exp_resp);
    end
  endtask

  task automatic finish_rsp(input string name);
    bit done;
    done = 0;
    for (int n = 0; n < 60; n++) begin
      if (rsp_valid && rsp_ready) begin done = 1; break; end
      @(negedge ACLK);
    end
    @(posedge ACLK);
    #1;
    if (!done) timeout({name, "_rsp_done"});
  endtask

  task automatic applyStimulus();
    int acc, acc2, d, d1;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    check_en = 1'b1;
    @(negedge ACLK);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_awvalid", bus.awvalid, 0);
    chk("reset_arvalid", bus.arvalid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_awaddr", bus.awaddr, 0);
    chk("reset_wstrb", bus.wstrb, 0);
    @(posedge ACLK);
    #1;

    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, acc);
    wait_rsp("wr_zero_wait", 3, acc, 32'h0, 2'b00, d);
    finish_rsp("wr_zero_wait");

    aw_dly = 1; w_dly = 4; s_bresp = 2'b01;
    issue(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h5, acc);
    wait_rsp("wr_skew", 7, acc, 32'h0, 2'b01, d);
    finish_rsp("wr_skew");

    aw_dly = 0; w_dly = 0; ar_dly = 2; r_dly = 3;
    s_rdata = 32'h1234_5678; s_rresp = 2'b10;
    issue(1'b0, 32'h0000_0030, 32'hFFFF_FFFF, 4'hF, acc);
    wait_rsp("rd_wait", 8, acc, 32'h1234_5678, 2'b10, d);
    finish_rsp("rd_wait");

    ar_dly = 0; r_dly = 0; rsp_dly = 5; s_bresp = 2'b11;
    s_rdata = 32'hA5A5_0001; s_rresp = 2'b01;
    issue(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'h0, acc);
    wait_rsp("bp_wr", 3, acc, 32'h0, 2'b11, d1);
    @(posedge ACLK);
    #1;
    issue(1'b0, 32'h0000_0048, 32'h0, 4'h0, acc2);
    chk("bp_accept_gap", acc2 - d1, 6);
    wait_rsp("bp_rd", 3, acc2, 32'hA5A5_0001, 2'b01, d);
    finish_rsp("bp_rd");

    rsp_dly = 0; aw_dly = 20; s_bresp = 2'b00;
    issue(1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'h3, acc);
    @(negedge ACLK);
    chk("pre_reset_awvalid", bus.awvalid, 1);
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    txq[txq.size()-1].rst = cyc + 1;
    txq[txq.size()-1].r   = cyc + 1;
    last_r = cyc + 1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("midrst_awvalid", bus.awvalid, 0);
    chk("midrst_wvalid", bus.wvalid, 0);
    chk("midrst_bready", bus.bready, 0);
    chk("midrst_arvalid", bus.arvalid, 0);
    chk("midrst_rready", bus.rready, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(posedge ACLK);
    #1;

    aw_dly = 0; ready_first = 1'b1; s_rdata = 32'h0F0F_F0F0; s_rresp = 2'b00;
    @(posedge ACLK);
    #1;
    issue(1'b1, 32'h0000_0060, 32'h1357_9BDF, 4'hC, acc);
    wait_rsp("rf_wr", 3, acc, 32'h0, 2'b00, d);
    finish_rsp("rf_wr");
    issue(1'b0, 32'h0000_0064, 32'h0, 4'h0, acc);
    wait_rsp("rf_rd", 3, acc, 32'h0F0F_F0F0, 2'b00, d);
    finish_rsp("rf_rd");
  endtask

  task automatic checkOutput();
    repeat (3) @(posedge ACLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    applyStimulus();
    checkOutput();
  end
endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- AXI4-Lite initiator (master) that drives the slave side of the bus: issues single read and write transactions on behalf of a simple local command/response port.
- Exactly one transaction outstanding at a time.
- Sits between internal control logic (CPU-less sequencer, test driver) and any AXI4-Lite slave register block.

Parameters:
- ADDRESS_WIDTH, 32, width of AWADDR/ARADDR and cmd_addr
- DATA_WIDTH, 32, width of WDATA/RDATA; legal values 32 or 64; strobe width is DATA_WIDTH/8

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  local command valid
- cmd_ready  out  1  master idle; command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDRESS_WIDTH  transaction address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  local consumer accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP from the slave, unmodified
- M_AXI_AWADDR  out  ADDRESS_WIDTH  write address
- M_AXI_AWVALID  out  1  write address valid
- M_AXI_AWREADY  in  1  write address ready
- M_AXI_WDATA  out  DATA_WIDTH  write data
- M_AXI_WSTRB  out  DATA_WIDTH/8  write strobes
- M_AXI_WVALID  out  1  write data valid
- M_AXI_WREADY  in  1  write data ready
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  write response valid
- M_AXI_BREADY  out  1  write response ready
- M_AXI_ARADDR  out  ADDRESS_WIDTH  read address
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARREADY  in  1  read address ready
- M_AXI_RDATA  in  DATA_WIDTH  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  read data ready

Behaviour:
- All outputs are registered.
- Reset values:
  - State IDLE; cmd_ready = 1.
  - All *VALID outputs and BREADY/RREADY = 0.
  - rsp_valid = 0; rsp_rdata, rsp_resp, address, data and strobe outputs = 0.
- Reset mid-transaction: at the next edge, return to IDLE and drop all valids/readies. The in-flight AXI transaction is abandoned; the bus is assumed reset together with the slave.
- State machine: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - On cmd_valid && cmd_ready, latch addr/wdata/wstrb and set cmd_ready = 0 at the next edge.
  - Write command: assert AWVALID and WVALID at the next edge; go to WR_ADDR_DATA.
  - Read command: assert ARVALID at the next edge; go to RD_ADDR.
  - Command-to-VALID latency is 1 cycle.
- WR_ADDR_DATA:
  - AW and W complete independently.
  - AWVALID clears at the edge where AWVALID && AWREADY. WVALID clears at the edge where WVALID && WREADY.
  - Either order or the same cycle is legal.
  - When both have completed, assert BREADY at that edge and go to WR_RESP.
  - Never deassert a VALID before its handshake. Address/data/strobe are stable while VALID is high.
- WR_RESP: on BVALID && BREADY, at that edge:
  - capture BRESP into rsp_resp and set rsp_rdata = 0;
  - set BREADY = 0 and rsp_valid = 1;
  - go to RESP.
- RD_ADDR: on ARVALID && ARREADY, at that edge set ARVALID = 0 and RREADY = 1; go to RD_DATA.
- RD_DATA: on RVALID && RREADY, at that edge:
  - capture RDATA and RRESP;
  - set RREADY = 0 and rsp_valid = 1;
  - go to RESP.
- RESP:
  - Hold rsp_valid and the response fields stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid = 0, cmd_ready = 1, go to IDLE.
  - Next command acceptance is possible the following cycle.
- Response codes (OKAY/EXOKAY/SLVERR/DECERR) are passed through unmodified; no retry.
- wstrb = 0 is legal and is forwarded unchanged.
- Slave ready signals asserted before VALID (ready-first) are handled: the handshake completes at the first edge where both are high.
- Minimum write latency, cmd accept to rsp_valid, with zero-wait slave: 3 cycles. Minimum read latency: 3 cycles.

Test Plan:
- Write, zero-wait slave: cmd addr 0x0000_0010, wdata 0xDEAD_BEEF, wstrb 0xF.
  - Expect AWVALID and WVALID 1 cycle after accept, both handshaking the same cycle.
  - Expect BREADY next; rsp_valid with rsp_resp = 2'b00 and rsp_rdata = 0.
- Write with skewed readies: AWREADY at +1 cycle, WREADY at +4 cycles.
  - Expect AWVALID to drop after its handshake and WVALID to stay high with stable WDATA until +4.
  - Expect BREADY only after both handshakes.
- Read from slave returning RDATA 0x1234_5678, RRESP = 2'b10 after 3 wait cycles on RVALID.
  - Expect ARVALID held until ARREADY, then RREADY held high.
  - Expect rsp_rdata = 0x1234_5678 and rsp_resp = 2'b10.
- Response back-pressure: rsp_ready low for 5 cycles.
  - Expect rsp_valid and data stable throughout and cmd_ready = 0.
  - Expect cmd_ready = 1 the cycle after rsp_ready.
  - Expect a second cmd_valid held during this window to be accepted only then.
- ARESET asserted while in WR_ADDR_DATA with AWREADY = 0: after the edge, all VALID/READY outputs = 0, cmd_ready = 1, rsp_valid = 0.
- Ready-first slave: AWREADY, WREADY, ARREADY tied high, BVALID/RVALID asserted 1 cycle after the request.
  - Expect each handshake on the first VALID cycle and minimum 3-cycle latency for both read and write.
